// File: rtl/synthesizer_top_p_core.sv
// Polyphonic triangle-wave synthesizer: Avalon-MM note commands drive per-voice
// phase accumulators; the mixed sample goes out on Avalon-ST, a status port and a 1-bit delta-sigma DAC.
module synthesizer_top_p_core #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned SAMPLE_DIV = 520,
  parameter int unsigned NUM_VOICES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        avs_s0_write,
  input  logic        avs_s0_read,
  input  logic [31:0] avs_s0_writedata,
  output logic [31:0] avs_s0_readdata,
  output logic        o_dac_out,
  output logic [31:0] aso_ss0_data,
  output logic        aso_ss0_valid,
  output logic [23:0] current_out
);

  localparam int unsigned CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [CW-1:0]         sample_cnt;
  logic                  tick;
  logic [NUM_VOICES-1:0] active;
  logic [6:0]            voice_note [NUM_VOICES];
  logic [31:0]           voice_inc  [NUM_VOICES];
  logic [31:0]           phase      [NUM_VOICES];

  logic                  cmd_on;
  logic [6:0]            cmd_note;
  logic                  hit;
  logic [VW-1:0]         hit_idx;
  logic                  free_found;
  logic [VW-1:0]         free_idx;
  logic [15:0]           voice_smp;
  logic [23:0]           mix;
  logic [24:0]           dac_acc;
  logic                  unused_bits;

  // Top-octave increments (notes 120..131); lower octaves shift right.
  function automatic logic [31:0] note_inc(input logic [6:0] n);
    logic [3:0]  oct;
    logic [3:0]  semi;
    logic [31:0] tw;
    oct  = 4'(n / 7'd12);
    semi = 4'(n % 7'd12);
    case (semi)
      4'd0:    tw = 32'd374557749;
      4'd1:    tw = 32'd396830112;
      4'd2:    tw = 32'd420426858;
      4'd3:    tw = 32'd445426740;
      4'd4:    tw = 32'd471913192;
      4'd5:    tw = 32'd499974611;
      4'd6:    tw = 32'd529704648;
      4'd7:    tw = 32'd561202526;
      4'd8:    tw = 32'd594573365;
      4'd9:    tw = 32'd629928537;
      4'd10:   tw = 32'd667386037;
      default: tw = 32'd707070876;
    endcase
    return tw >> (4'd10 - oct);
  endfunction

  function automatic logic [15:0] tri_sample(input logic [15:0] p);
    logic [14:0] t;
    t = p[15] ? ~p[14:0] : p[14:0];
    return {t, 1'b0} - 16'h8000;
  endfunction

  assign cmd_on      = avs_s0_writedata[15];
  assign cmd_note    = avs_s0_writedata[14:8];
  assign tick        = (sample_cnt == CW'(SAMPLE_DIV - 1));
  assign o_dac_out   = dac_acc[24];
  assign unused_bits = ^{avs_s0_writedata[31:16], avs_s0_writedata[7:0], 32'(CLK_HZ / SAMPLE_DIV)};

  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (active[i] && (voice_note[i] == cmd_note)) begin
        hit     = 1'b1;
        hit_idx = VW'(i);
      end
      if (!active[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = VW'(i);
      end
    end
  end

  always_comb begin
    mix       = '0;
    voice_smp = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      voice_smp = tri_sample(phase[i][31:16]);
      if (active[i]) mix = mix + {{8{voice_smp[15]}}, voice_smp};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sample_cnt <= '0;
    else        sample_cnt <= tick ? '0 : sample_cnt + 1'b1;
  end

  // Command updates are written after the tick advance so a coincident
  // note-on restarts its voice at phase 0 instead of advancing it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active     <= '0;
      voice_note <= '{default: '0};
      voice_inc  <= '{default: '0};
      phase      <= '{default: '0};
    end else begin
      if (tick) begin
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
          if (active[i]) phase[i] <= phase[i] + voice_inc[i];
        end
      end
      if (avs_s0_write) begin
        if (cmd_on) begin
          if (!hit && free_found) begin
            active[free_idx]     <= 1'b1;
            voice_note[free_idx] <= cmd_note;
            voice_inc[free_idx]  <= note_inc(cmd_note);
            phase[free_idx]      <= '0;
          end
        end else if (cmd_note == 7'd127) begin
          active <= '0;
        end else if (hit) begin
          active[hit_idx] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      current_out     <= '0;
      aso_ss0_data    <= '0;
      aso_ss0_valid   <= 1'b0;
      avs_s0_readdata <= '0;
      dac_acc         <= '0;
    end else begin
      aso_ss0_valid <= tick;
      if (tick) begin
        current_out  <= mix;
        aso_ss0_data <= {{8{mix[23]}}, mix};
      end
      if (avs_s0_read) avs_s0_readdata <= 32'(active);
      dac_acc <= {1'b0, dac_acc[23:0]} + {1'b0, current_out ^ 24'h800000};
    end
  end

endmodule

// File: tb/tb_synthesizer_top_p_core.sv
// Directed bench for synthesizer_top_p_core: note allocation, triangle mix,
// tick timing, DAC density and reset behaviour against a small reference model.
module tb_synthesizer_top_p_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        write;
  logic        read;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        dac;
  logic [31:0] st_data;
  logic        st_valid;
  logic [23:0] cur;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_ph  [8];
  logic [31:0] m_inc [8];
  bit          m_act [8];

  always #5 clk = ~clk;

  synthesizer_top_p_core #(
    .CLK_HZ    (50_000_000),
    .SAMPLE_DIV(520),
    .NUM_VOICES(8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .avs_s0_write    (write),
    .avs_s0_read     (read),
    .avs_s0_writedata(wdata),
    .avs_s0_readdata (rdata),
    .o_dac_out       (dac),
    .aso_ss0_data    (st_data),
    .aso_ss0_valid   (st_valid),
    .current_out     (cur)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tw_of(input int s);
    real f;
    f = 440.0 * (2.0 ** ((120.0 + s - 69.0) / 12.0));
    return 32'(longint'(f * 4294967296.0 / 96000.0));
  endfunction

  function automatic logic [31:0] inc_of(input int n);
    logic [31:0] tw;
    tw = tw_of(n % 12);
    return tw >> (10 - n / 12);
  endfunction

  function automatic int tri_s(input logic [31:0] ph);
    logic [15:0] p;
    logic [14:0] t;
    p = ph[31:16];
    t = p[15] ? ~p[14:0] : p[14:0];
    return int'({t, 1'b0}) - 32768;
  endfunction

  function automatic logic [23:0] model_mix();
    int sum = 0;
    for (int i = 0; i < 8; i++) if (m_act[i]) sum += tri_s(m_ph[i]);
    return 24'(sum);
  endfunction

  task automatic model_tick();
    for (int i = 0; i < 8; i++) if (m_act[i]) m_ph[i] = m_ph[i] + m_inc[i];
  endtask

  task automatic model_on(input int slot, input int n);
    m_act[slot] = 1'b1;
    m_ph[slot]  = '0;
    m_inc[slot] = inc_of(n);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_act[i] = 1'b0;
  endtask

  task automatic send(input logic [15:0] cmd);
    @(negedge clk);
    write = 1'b1;
    wdata = {16'h0000, cmd};
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic read_mask(input string tag, input logic [31:0] exp);
    @(negedge clk);
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    chk(tag, rdata, exp);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (st_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic expect_tick(input string tag);
    bit          ok;
    logic [23:0] e;
    wait_valid(ok);
    chk({tag, "_valid"}, 32'(ok), 32'd1);
    e = model_mix();
    chk(tag, {8'h00, cur}, {8'h00, e});
    chk({tag, "_st"}, st_data, {{8{e[23]}}, e});
    model_tick();
  endtask

  initial begin
    bit ok;
    int k;
    int ones;

    reset = 1'b0;
    write = 1'b0;
    read  = 1'b0;
    wdata = '0;
    model_clear();

    // Command during reset must be discarded.
    repeat (2) @(negedge clk);
    write = 1'b1;
    wdata = 32'h0000_DB00;
    @(negedge clk);
    write = 1'b0;
    @(negedge clk);
    chk("rst_current_out", {8'h00, cur}, 32'h0);
    chk("rst_st_data", st_data, 32'h0);
    chk("rst_st_valid", 32'(st_valid), 32'h0);
    chk("rst_readdata", rdata, 32'h0);
    chk("rst_dac", 32'(dac), 32'h0);
    reset = 1'b1;

    k = 0;
    for (int i = 1; i <= 1000; i++) begin
      @(negedge clk);
      if (st_valid) begin
        k = i;
        break;
      end
    end
    chk("first_tick_latency", k, 520);
    @(negedge clk);
    chk("valid_one_cycle", 32'(st_valid), 32'h0);
    k = 0;
    for (int i = 2; i <= 1000; i++) begin
      @(negedge clk);
      if (st_valid) begin
        k = i;
        break;
      end
    end
    chk("tick_period", k, 520);
    chk("idle_current_out", {8'h00, cur}, 32'h0);

    ones = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (dac) ones++;
    end
    chk("dac_idle_density", ones, 500);
    read_mask("idle_mask", 32'h0);

    // G6 on with a simultaneous read: read sees the mask before the write.
    wait_valid(ok);
    chk("sync_valid", 32'(ok), 32'd1);
    @(negedge clk);
    write = 1'b1;
    read  = 1'b1;
    wdata = 32'h0000_DB00;
    @(negedge clk);
    write = 1'b0;
    read  = 1'b0;
    chk("rd_before_wr", rdata, 32'h0);
    model_on(0, 91);
    read_mask("g6_mask", 32'h01);
    send(16'hDB00);
    send(16'h4900);
    read_mask("g6_dup_off_other", 32'h01);
    for (int i = 0; i < 5; i++) expect_tick($sformatf("g6_t%0d", i));

    send(16'h5B00);
    model_clear();
    read_mask("g6_off_mask", 32'h0);
    expect_tick("g6_off_silent");

    // Two voices.
    send(16'hDB00);
    send(16'hBC00);
    model_on(0, 91);
    model_on(1, 60);
    send(16'hDB00);
    read_mask("two_mask", 32'h03);
    for (int i = 0; i < 4; i++) expect_tick($sformatf("two_t%0d", i));

    // Note-off landing on a tick edge: that tick still mixes the voice.
    repeat (519) @(negedge clk);
    write = 1'b1;
    wdata = 32'h0000_5B00;
    @(negedge clk);
    write = 1'b0;
    chk("coinc_off_valid", 32'(st_valid), 32'd1);
    chk("coinc_off_mix", {8'h00, cur}, {8'h00, model_mix()});
    model_tick();
    m_act[0] = 1'b0;
    expect_tick("after_coinc_off");

    // Note-on landing on a tick edge: excluded from that mix, starts at phase 0.
    repeat (519) @(negedge clk);
    write = 1'b1;
    wdata = 32'h0000_DB00;
    @(negedge clk);
    write = 1'b0;
    chk("coinc_on_valid", 32'(st_valid), 32'd1);
    chk("coinc_on_mix", {8'h00, cur}, {8'h00, model_mix()});
    model_tick();
    model_on(0, 91);
    expect_tick("coinc_on_t0");
    expect_tick("coinc_on_t1");
    read_mask("coinc_mask", 32'h03);

    // Fill every voice, overflow, then stop-all.
    send(16'h7F00);
    model_clear();
    read_mask("stopall_mask0", 32'h0);
    for (int n = 64; n < 73; n++) send(16'(16'h8000 | (16'(n) << 8)));
    read_mask("full_mask", 32'hFF);
    send(16'h7F00);
    read_mask("stopall_mask1", 32'h0);
    expect_tick("stopall_silent");

    // Reset mid-note clears outputs immediately.
    send(16'hDB00);
    model_on(0, 91);
    expect_tick("pre_rst_t0");
    expect_tick("pre_rst_t1");
    read_mask("pre_rst_mask", 32'h01);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_current_out", {8'h00, cur}, 32'h0);
    chk("mid_rst_st_data", st_data, 32'h0);
    chk("mid_rst_valid", 32'(st_valid), 32'h0);
    chk("mid_rst_readdata", rdata, 32'h0);
    chk("mid_rst_dac", 32'(dac), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    read_mask("post_rst_mask", 32'h0);
    expect_tick("post_rst_silent");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
